chunked_addsub: RTL and testbench
=================================

Name: chunked_addsub

Overview:
- Parametrised multi-cycle adder/subtractor. Successor to the fixed 16-bit ripple adder.
- Operates on WIDTH-bit operands, CHUNK bits per clock, and holds the carry in a register between chunks.
- Adds subtract mode, signed-overflow and zero flags, and valid/ready handshakes on both sides.
- Sits between operand registers and downstream datapath logic where ripple delay must be bounded per cycle.

Parameters:
WIDTH, 16, operand and result width in bits.
CHUNK, 4, bits processed per cycle. WIDTH mod CHUNK must be 0. NCHUNK = WIDTH/CHUNK.

Ports:
clk  in  1  clock, all state updates on the rising edge.
rst  in  1  synchronous active-high reset.
in_valid  in  1  operands present.
in_ready  out  1  block can accept operands; high only in IDLE.
a  in  WIDTH  operand A, unsigned or two's complement.
b  in  WIDTH  operand B.
sub  in  1  0: A+B; 1: A-B.
out_valid  out  1  result available; high only in DONE.
out_ready  in  1  downstream accepts result.
sum  out  WIDTH  result, registered.
cout  out  1  final carry out. For subtract, 1 means no borrow.
ovf  out  1  signed two's-complement overflow.
zero  out  1  sum == 0.

Behaviour:
- Reset: rst high at a clock edge forces state=IDLE, chunk index=0, carry=0, sum=0, cout=0, ovf=0, zero=0.
  - After that edge: out_valid=0, in_ready=1.
  - Reset mid-RUN or mid-DONE aborts the operation. No result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, latch: A; B' = sub ? ~b : b; carry=sub; idx=0. Go to RUN.
  - a, b and sub are sampled only on this accept edge. Later changes are ignored.
- RUN:
  - in_ready=0, out_valid=0.
  - Each edge computes {c, s} = A[idx*CHUNK +: CHUNK] + B'[idx*CHUNK +: CHUNK] + carry.
  - Writes s into sum at the same slice, sets carry=c, increments idx.
  - On the edge processing idx=NCHUNK-1:
    - cout = c.
    - ovf = (A[MSB]==B'[MSB]) && (s_msb != A[MSB]).
    - zero = (full new sum == 0).
    - Go to DONE.
- Latency: the accept edge is E0. The result and out_valid=1 are visible after edge E0+NCHUNK (4 cycles at defaults).
  - With CHUNK==WIDTH, RUN lasts one cycle.
- DONE:
  - out_valid=1. sum, cout, ovf and zero hold stable.
  - On an edge with out_ready=1, go to IDLE. out_valid=0 after that edge.
  - in_valid is ignored in DONE. A new operation is accepted no earlier than the cycle after DONE exits, so throughput is at most one operation per NCHUNK+2 cycles.
  - out_ready is ignored outside DONE.
- Flag outputs (sum, cout, ovf, zero) keep their last values in IDLE until overwritten by the next operation. During RUN, sum chunks update progressively; consumers must use sum only when out_valid=1.
- Arithmetic is modulo 2^WIDTH. Wrap-around is reported via cout/ovf only, never saturated.

Test Plan:
1. WIDTH=16, CHUNK=4. Reset, then a=0x1234, b=0x4321, sub=0 -> out_valid after 4 edges; sum=0x5555, cout=0, ovf=0, zero=0.
2. a=0xFFFF, b=0x0001, sub=0 (carry ripples through all chunks) -> sum=0x0000, cout=1, zero=1, ovf=0.
3. a=0x0005, b=0x0007, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
   a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
4. a=0x7FFF, b=0x0001, sub=0 -> sum=0x8000, cout=0, ovf=1, zero=0.
5. Hold out_ready=0 for 5 cycles in DONE, pulse in_valid with new operands -> out_valid, sum and flags stable, in_ready=0, new operands not accepted. Then out_ready=1 -> IDLE next edge, in_ready=1.
6. Assert rst for one edge during the second RUN cycle -> after that edge: state IDLE, out_valid=0, sum=0, flags=0, in_ready=1, no result emitted. Then run a=0x0001, b=0x0001 -> sum=0x0002.

Source files
------------

// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor that processes CHUNK bits per
// clock and carries between chunks in a register, so the ripple path per
// cycle is bounded to CHUNK bits. Valid/ready handshakes on both sides,
// with carry-out, signed-overflow and zero flags.
module chunked_addsub #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned NCHUNK = WIDTH / CHUNK;
   localparam int unsigned IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   if (WIDTH % CHUNK != 0) begin : g_bad_params
      $error("chunked_addsub: WIDTH must be a multiple of CHUNK");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_idx;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;      // already inverted for subtract
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             r_zero;

   int unsigned      w_base;
   logic [CHUNK-1:0] w_a_chunk;
   logic [CHUNK-1:0] w_b_chunk;
   logic [CHUNK-1:0] w_s;
   logic             w_c;
   logic [WIDTH-1:0] w_sum_next;
   logic             w_last;

   // One chunk of the addition plus the sum as it will look after this edge.
   always_comb begin
      // NOTE: every variable gets a default before any conditional or partial
      // write, so no path can leave it unassigned and infer a latch.
      w_base     = 32'(r_idx) * CHUNK;
      w_a_chunk  = r_a[w_base +: CHUNK];
      w_b_chunk  = r_b[w_base +: CHUNK];
      {w_c, w_s} = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + (CHUNK + 1)'(r_carry);
      w_sum_next = r_sum;
      w_sum_next[w_base +: CHUNK] = w_s;
      w_last     = (r_idx == LAST_IDX);
   end

   // Operand capture on the accept edge; B is stored pre-inverted for subtract.
   always_ff @(posedge clk) begin
      // NOTE: operand registers carry no reset: they are only read in RUN,
      // which is always entered through a load, so reset would add nothing.
      if (!rst && r_state == S_IDLE && in_valid) begin
         r_a <= a;
         r_b <= sub ? ~b : b;
      end
   end

   // Control FSM and registered result/flags.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) begin
         r_state <= S_IDLE;
         r_idx   <= '0;
         r_carry <= 1'b0;
         r_sum   <= '0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_zero  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_carry <= sub;   // +1 completes the two's complement of B
                  r_idx   <= '0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_sum   <= w_sum_next;
               r_carry <= w_c;
               r_idx   <= r_idx + 1'b1;
               if (w_last) begin
                  r_cout  <= w_c;
                  r_ovf   <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s[CHUNK-1] != r_a[WIDTH-1]);
                  r_zero  <= (w_sum_next == '0);
                  r_idx   <= '0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == S_IDLE);
   assign out_valid = (r_state == S_DONE);
   assign sum       = r_sum;
   assign cout      = r_cout;
   assign ovf       = r_ovf;
   assign zero      = r_zero;

endmodule

// File: tb/tb_chunked_addsub.sv
// Testbench for chunked_addsub: directed corner cases plus randomized
// operations; expected results are queued at issue time and compared by an
// independent monitor whenever the DUT presents a result.
module tb_chunked_addsub;

   localparam int W   = 16;
   localparam int C   = 4;
   localparam int NCH = W / C;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
      logic         zero;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   auto_ready = 1'b1;
   bit   manual_ready = 1'b0;

   chunked_addsub #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: plain integer arithmetic, signed range test for overflow,
   // "no borrow" (a >= b) as carry-out for subtraction.
   function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic ms);
      exp_t e;
      int   ua, ub, sa, sb, ur, sr;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      if (ms) begin
         ur     = ua - ub;
         sr     = sa - sb;
         e.cout = (ua >= ub);
      end else begin
         ur     = ua + ub;
         sr     = sa + sb;
         e.cout = (ur >= (1 << W));
      end
      e.sum  = ur[W-1:0];
      e.ovf  = (sr > (1 << (W - 1)) - 1) || (sr < -(1 << (W - 1)));
      e.zero = (e.sum == '0);
      return e;
   endfunction

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'(16'h8000);
         3:       return W'(16'h7FFF);
         4:       return W'(1);
         default: return W'($urandom);
      endcase
   endfunction

   // Downstream ready: random back-pressure, or a value forced by the test.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = auto_ready ? ($urandom_range(0, 3) != 0) : manual_ready;
      end
   end

   // Monitor: one scoreboard pop per result presentation.
   initial begin
      bit   seen;
      exp_t e;
      seen = 1'b0;
      forever begin
         @(negedge clk);
         if (out_valid && !seen) begin
            seen = 1'b1;
            check("result_expected", 32'(sb_q.size() != 0), 32'(1));
            if (sb_q.size() != 0) begin
               e = sb_q.pop_front();
               check("sum",  32'(sum),  32'(e.sum));
               check("cout", 32'(cout), 32'(e.cout));
               check("ovf",  32'(ovf),  32'(e.ovf));
               check("zero", 32'(zero), 32'(e.zero));
            end
         end else if (!out_valid) begin
            seen = 1'b0;
         end
      end
   end

   // Issue one operation, scramble inputs after accept, check latency.
   task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_in, input logic ts);
      int n;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_wait", 32'(in_ready), 32'(1));
      in_valid = 1'b1;
      a        = ta;
      b        = tb_in;
      sub      = ts;
      sb_q.push_back(model(ta, tb_in, ts));
      @(negedge clk);
      in_valid = 1'b0;
      a        = W'($urandom);
      b        = W'($urandom);
      sub      = 1'($urandom_range(0, 1));
      n = 0;
      while (!out_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(NCH));
   endtask

   initial begin
      exp_t e;
      int   valid_seen;

      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready",  32'(in_ready),  32'(1));
      check("rst_out_valid", 32'(out_valid), 32'(0));
      check("rst_sum",       32'(sum),       32'(0));
      check("rst_cout",      32'(cout),      32'(0));
      check("rst_ovf",       32'(ovf),       32'(0));
      check("rst_zero",      32'(zero),      32'(0));
      rst = 1'b0;

      // Directed corner cases
      do_op(16'h1234, 16'h4321, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0);
      do_op(16'h0005, 16'h0007, 1'b1);
      do_op(16'h8000, 16'h0001, 1'b1);
      do_op(16'h7FFF, 16'h0001, 1'b0);

      // Back-pressure in DONE with new operands offered
      manual_ready = 1'b0;
      auto_ready   = 1'b0;
      do_op(16'h1111, 16'h2222, 1'b1);
      e = model(16'h1111, 16'h2222, 1'b1);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         a        = W'($urandom);
         b        = W'($urandom);
         sub      = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid), 32'(1));
         check("hold_in_ready",  32'(in_ready),  32'(0));
         check("hold_sum",       32'(sum),       32'(e.sum));
         check("hold_cout",      32'(cout),      32'(e.cout));
         check("hold_ovf",       32'(ovf),       32'(e.ovf));
         check("hold_zero",      32'(zero),      32'(e.zero));
      end
      in_valid     = 1'b0;
      manual_ready = 1'b1;
      @(posedge clk);
      #3;
      @(negedge clk);
      check("release_still_valid", 32'(out_valid), 32'(1));
      @(negedge clk);
      check("release_out_valid", 32'(out_valid), 32'(0));
      check("release_in_ready",  32'(in_ready),  32'(1));
      manual_ready = 1'b0;
      auto_ready   = 1'b1;
      repeat (4) @(negedge clk);
      check("hold_no_extra_op", 32'(out_valid), 32'(0));

      // Reset during the second RUN cycle aborts the operation
      in_valid = 1'b1;
      a        = 16'h1234;
      b        = 16'h1111;
      sub      = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("abort_out_valid", 32'(out_valid), 32'(0));
      check("abort_in_ready",  32'(in_ready),  32'(1));
      check("abort_sum",       32'(sum),       32'(0));
      check("abort_cout",      32'(cout),      32'(0));
      check("abort_ovf",       32'(ovf),       32'(0));
      check("abort_zero",      32'(zero),      32'(0));
      valid_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (out_valid) valid_seen++;
      end
      check("abort_no_result", 32'(valid_seen), 32'(0));
      do_op(16'h0001, 16'h0001, 1'b0);

      // Randomized operations
      for (int i = 0; i < 40; i++) begin
         do_op(pick(), pick(), 1'($urandom_range(0, 1)));
      end

      repeat (10) @(negedge clk);
      check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
